// File: rtl/reg_status_file_if.sv
// rtl/reg_status_file_if.sv - rename/commit/operand-read bundle for reg_status_file
interface reg_status_file_if #(
  parameter int REG_W = 5,
  parameter int TAG_W = 4,
  parameter int XLEN  = 32
);
  logic             issue_valid;
  logic [REG_W-1:0] issue_rd;
  logic [TAG_W-1:0] issue_tag;
  logic             commit_valid;
  logic [TAG_W-1:0] commit_tag;
  logic [XLEN-1:0]  commit_val;
  logic             predict_fail;
  logic [REG_W-1:0] rs1_idx;
  logic [REG_W-1:0] rs2_idx;
  logic [XLEN-1:0]  rs1_val;
  logic [TAG_W-1:0] rs1_tag;
  logic             rs1_ready;
  logic [XLEN-1:0]  rs2_val;
  logic [TAG_W-1:0] rs2_tag;
  logic             rs2_ready;

  modport master (
    output issue_valid, issue_rd, issue_tag,
    output commit_valid, commit_tag, commit_val,
    output predict_fail, rs1_idx, rs2_idx,
    input  rs1_val, rs1_tag, rs1_ready,
    input  rs2_val, rs2_tag, rs2_ready
  );

  modport slave (
    input  issue_valid, issue_rd, issue_tag,
    input  commit_valid, commit_tag, commit_val,
    input  predict_fail, rs1_idx, rs2_idx,
    output rs1_val, rs1_tag, rs1_ready,
    output rs2_val, rs2_tag, rs2_ready
  );
endinterface

// File: rtl/reg_status_file.sv
// rtl/reg_status_file.sv - architectural registers with per-register rename tag and commit bypass
module reg_status_file #(
  parameter int REG_NUM = 32,
  parameter int REG_W   = 5,
  parameter int TAG_W   = 4,
  parameter int XLEN    = 32
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  reg_status_file_if.slave    bus
);

  typedef struct packed {
    logic             ready;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  val;
  } rd_res_t;

  logic [XLEN-1:0]    val_q [REG_NUM];
  logic [XLEN-1:0]    val_d [REG_NUM];
  logic [TAG_W-1:0]   tag_q [REG_NUM];
  logic [TAG_W-1:0]   tag_d [REG_NUM];
  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;

  logic [REG_W-1:0]   rd_idx [2];
  rd_res_t            rd_res [2];

  // Next state: commit CAM first, then flush or issue override the busy bits.
  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (rdy_in) begin
      for (int r = 1; r < REG_NUM; r++) begin
        if (bus.commit_valid && busy_q[r] && (tag_q[r] == bus.commit_tag)) begin
          val_d[r]  = bus.commit_val;
          busy_d[r] = 1'b0;
        end
      end
      if (bus.predict_fail) begin
        busy_d = '0;
      end else if (bus.issue_valid && (bus.issue_rd != '0)) begin
        busy_d[bus.issue_rd] = 1'b1;
        tag_d[bus.issue_rd]  = bus.issue_tag;
      end
    end
    val_d[0]  = '0;
    tag_d[0]  = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int r = 0; r < REG_NUM; r++) begin
        val_q[r] <= '0;
        tag_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      val_q  <= val_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
    end
  end

  assign rd_idx[0] = bus.rs1_idx;
  assign rd_idx[1] = bus.rs2_idx;

  // Reads see pre-edge state; a same-cycle issue is invisible, a matching commit is forwarded.
  for (genvar p = 0; p < 2; p++) begin : g_read
    always_comb begin
      rd_res[p].ready = 1'b1;
      rd_res[p].tag   = tag_q[rd_idx[p]];
      rd_res[p].val   = val_q[rd_idx[p]];
      if (rd_idx[p] == '0) begin
        rd_res[p].tag = '0;
        rd_res[p].val = '0;
      end else if (busy_q[rd_idx[p]]) begin
        if (bus.commit_valid && (bus.commit_tag == tag_q[rd_idx[p]])) begin
          rd_res[p].val = bus.commit_val;
        end else begin
          rd_res[p].ready = 1'b0;
        end
      end
    end
  end

  assign bus.rs1_ready = rd_res[0].ready;
  assign bus.rs1_tag   = rd_res[0].tag;
  assign bus.rs1_val   = rd_res[0].val;
  assign bus.rs2_ready = rd_res[1].ready;
  assign bus.rs2_tag   = rd_res[1].tag;
  assign bus.rs2_val   = rd_res[1].val;

endmodule

// File: tb/tb_reg_status_file.sv
// tb/tb_reg_status_file.sv - directed self-checking bench for reg_status_file
module tb_reg_status_file;
  logic clk_in;
  logic rst_in;
  logic rdy_in;
  int   checks;
  int   failures;

  reg_status_file_if #(.REG_W(5), .TAG_W(4), .XLEN(32)) bus ();

  reg_status_file #(.REG_NUM(32), .REG_W(5), .TAG_W(4), .XLEN(32)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_inputs();
    bus.issue_valid  = 1'b0;
    bus.issue_rd     = '0;
    bus.issue_tag    = '0;
    bus.commit_valid = 1'b0;
    bus.commit_tag   = '0;
    bus.commit_val   = '0;
    bus.predict_fail = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [3:0] tag);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = rd;
    bus.issue_tag   = tag;
  endtask

  task automatic commit(input logic [3:0] tag, input logic [31:0] val);
    bus.commit_valid = 1'b1;
    bus.commit_tag   = tag;
    bus.commit_val   = val;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.rs1_idx = 5'd5;
    bus.rs2_idx = 5'd0;
    rdy_in = 1'b1;
    rst_in = 1'b1;
    step();
    step();
    rst_in = 1'b0;
    #1;
    checks++; if (bus.rs1_ready !== 1'b1) begin failures++; $display("FAIL reset_rs1_ready got=%0h exp=1", bus.rs1_ready); end
    checks++; if (bus.rs1_val !== 32'h0) begin failures++; $display("FAIL reset_rs1_val got=%0h exp=0", bus.rs1_val); end
    checks++; if (bus.rs1_tag !== 4'h0) begin failures++; $display("FAIL reset_rs1_tag got=%0h exp=0", bus.rs1_tag); end
    checks++; if (bus.rs2_ready !== 1'b1) begin failures++; $display("FAIL reset_rs2_ready got=%0h exp=1", bus.rs2_ready); end
    checks++; if (bus.rs2_val !== 32'h0) begin failures++; $display("FAIL reset_rs2_val got=%0h exp=0", bus.rs2_val); end
  endtask

  task automatic test_issue_commit();
    issue(5'd3, 4'd7);
    step();
    clear_inputs();
    bus.rs1_idx = 5'd3;
    #1;
    checks++; if (bus.rs1_ready !== 1'b0) begin failures++; $display("FAIL ic_pending_ready got=%0h exp=0", bus.rs1_ready); end
    checks++; if (bus.rs1_tag !== 4'd7) begin failures++; $display("FAIL ic_pending_tag got=%0h exp=7", bus.rs1_tag); end
    commit(4'd7, 32'hDEADBEEF);
    #1;
    checks++; if (bus.rs1_ready !== 1'b1) begin failures++; $display("FAIL ic_bypass_ready got=%0h exp=1", bus.rs1_ready); end
    checks++; if (bus.rs1_val !== 32'hDEADBEEF) begin failures++; $display("FAIL ic_bypass_val got=%0h exp=deadbeef", bus.rs1_val); end
    step();
    clear_inputs();
    #1;
    checks++; if (bus.rs1_ready !== 1'b1) begin failures++; $display("FAIL ic_after_ready got=%0h exp=1", bus.rs1_ready); end
    checks++; if (bus.rs1_val !== 32'hDEADBEEF) begin failures++; $display("FAIL ic_after_val got=%0h exp=deadbeef", bus.rs1_val); end
  endtask

  task automatic test_same_cycle();
    issue(5'd3, 4'd7);
    step();
    issue(5'd3, 4'd9);
    commit(4'd7, 32'h11);
    bus.rs1_idx = 5'd3;
    #1;
    checks++; if (bus.rs1_ready !== 1'b1) begin failures++; $display("FAIL sc_bypass_ready got=%0h exp=1", bus.rs1_ready); end
    checks++; if (bus.rs1_val !== 32'h11) begin failures++; $display("FAIL sc_bypass_val got=%0h exp=11", bus.rs1_val); end
    step();
    clear_inputs();
    #1;
    checks++; if (bus.rs1_ready !== 1'b0) begin failures++; $display("FAIL sc_renamed_ready got=%0h exp=0", bus.rs1_ready); end
    checks++; if (bus.rs1_tag !== 4'd9) begin failures++; $display("FAIL sc_renamed_tag got=%0h exp=9", bus.rs1_tag); end
  endtask

  task automatic test_flush();
    issue(5'd4, 4'd2);
    step();
    issue(5'd6, 4'd5);
    step();
    clear_inputs();
    bus.rs1_idx = 5'd4;
    bus.rs2_idx = 5'd6;
    #1;
    checks++; if (bus.rs1_ready !== 1'b0 || bus.rs1_tag !== 4'd2) begin failures++; $display("FAIL fl_pre_x4 got=%0h/%0h exp=0/2", bus.rs1_ready, bus.rs1_tag); end
    checks++; if (bus.rs2_ready !== 1'b0 || bus.rs2_tag !== 4'd5) begin failures++; $display("FAIL fl_pre_x6 got=%0h/%0h exp=0/5", bus.rs2_ready, bus.rs2_tag); end
    bus.predict_fail = 1'b1;
    issue(5'd8, 4'd6);
    commit(4'd5, 32'h66);
    step();
    clear_inputs();
    #1;
    checks++; if (bus.rs1_ready !== 1'b1 || bus.rs1_val !== 32'h0) begin failures++; $display("FAIL fl_x4 got=%0h/%0h exp=1/0", bus.rs1_ready, bus.rs1_val); end
    checks++; if (bus.rs2_ready !== 1'b1 || bus.rs2_val !== 32'h66) begin failures++; $display("FAIL fl_x6 got=%0h/%0h exp=1/66", bus.rs2_ready, bus.rs2_val); end
    bus.rs1_idx = 5'd8;
    bus.rs2_idx = 5'd3;
    #1;
    checks++; if (bus.rs1_ready !== 1'b1 || bus.rs1_val !== 32'h0) begin failures++; $display("FAIL fl_x8 got=%0h/%0h exp=1/0", bus.rs1_ready, bus.rs1_val); end
    checks++; if (bus.rs2_ready !== 1'b1 || bus.rs2_val !== 32'h11) begin failures++; $display("FAIL fl_x3_retained got=%0h/%0h exp=1/11", bus.rs2_ready, bus.rs2_val); end
  endtask

  task automatic test_x0();
    issue(5'd0, 4'd1);
    step();
    clear_inputs();
    bus.rs1_idx = 5'd0;
    #1;
    checks++; if (bus.rs1_ready !== 1'b1 || bus.rs1_val !== 32'h0 || bus.rs1_tag !== 4'h0) begin failures++; $display("FAIL x0_after_issue got=%0h/%0h/%0h exp=1/0/0", bus.rs1_ready, bus.rs1_val, bus.rs1_tag); end
    commit(4'd1, 32'h55);
    #1;
    checks++; if (bus.rs1_ready !== 1'b1 || bus.rs1_val !== 32'h0) begin failures++; $display("FAIL x0_commit_cycle got=%0h/%0h exp=1/0", bus.rs1_ready, bus.rs1_val); end
    step();
    clear_inputs();
    #1;
    checks++; if (bus.rs1_ready !== 1'b1 || bus.rs1_val !== 32'h0) begin failures++; $display("FAIL x0_after_commit got=%0h/%0h exp=1/0", bus.rs1_ready, bus.rs1_val); end
  endtask

  task automatic test_rdy_hold();
    issue(5'd2, 4'd3);
    step();
    clear_inputs();
    rdy_in = 1'b0;
    commit(4'd3, 32'h99);
    issue(5'd5, 4'd4);
    step();
    step();
    clear_inputs();
    bus.rs1_idx = 5'd2;
    bus.rs2_idx = 5'd5;
    #1;
    checks++; if (bus.rs1_ready !== 1'b0 || bus.rs1_tag !== 4'd3) begin failures++; $display("FAIL hold_x2 got=%0h/%0h exp=0/3", bus.rs1_ready, bus.rs1_tag); end
    checks++; if (bus.rs2_ready !== 1'b1) begin failures++; $display("FAIL hold_x5_issue_blocked got=%0h exp=1", bus.rs2_ready); end
    rdy_in = 1'b1;
    commit(4'd3, 32'h99);
    step();
    clear_inputs();
    #1;
    checks++; if (bus.rs1_ready !== 1'b1 || bus.rs1_val !== 32'h99) begin failures++; $display("FAIL hold_release_x2 got=%0h/%0h exp=1/99", bus.rs1_ready, bus.rs1_val); end
  endtask

  task automatic test_back_to_back();
    issue(5'd10, 4'd8);
    step();
    issue(5'd11, 4'd8);
    step();
    clear_inputs();
    bus.rs1_idx = 5'd10;
    bus.rs2_idx = 5'd11;
    #1;
    checks++; if (bus.rs1_ready !== 1'b0 || bus.rs2_ready !== 1'b0) begin failures++; $display("FAIL b2b_pending got=%0h/%0h exp=0/0", bus.rs1_ready, bus.rs2_ready); end
    commit(4'd8, 32'hAB);
    step();
    clear_inputs();
    #1;
    checks++; if (bus.rs1_ready !== 1'b1 || bus.rs1_val !== 32'hAB) begin failures++; $display("FAIL b2b_x10 got=%0h/%0h exp=1/ab", bus.rs1_ready, bus.rs1_val); end
    checks++; if (bus.rs2_ready !== 1'b1 || bus.rs2_val !== 32'hAB) begin failures++; $display("FAIL b2b_x11 got=%0h/%0h exp=1/ab", bus.rs2_ready, bus.rs2_val); end
  endtask

  task automatic test_reset_priority();
    issue(5'd12, 4'd3);
    step();
    clear_inputs();
    rdy_in = 1'b0;
    rst_in = 1'b1;
    commit(4'd3, 32'h77);
    step();
    rst_in = 1'b0;
    rdy_in = 1'b1;
    clear_inputs();
    bus.rs1_idx = 5'd12;
    bus.rs2_idx = 5'd2;
    #1;
    checks++; if (bus.rs1_ready !== 1'b1 || bus.rs1_val !== 32'h0) begin failures++; $display("FAIL rstp_x12 got=%0h/%0h exp=1/0", bus.rs1_ready, bus.rs1_val); end
    checks++; if (bus.rs2_ready !== 1'b1 || bus.rs2_val !== 32'h0) begin failures++; $display("FAIL rstp_x2 got=%0h/%0h exp=1/0", bus.rs2_ready, bus.rs2_val); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_in   = 1'b1;
    rdy_in   = 1'b1;
    bus.rs1_idx = '0;
    bus.rs2_idx = '0;
    clear_inputs();
    test_reset();
    test_issue_commit();
    test_same_cycle();
    test_flush();
    test_x0();
    test_rdy_hold();
    test_back_to_back();
    test_reset_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_status_file.md
Name: reg_status_file

Overview:
- Architectural register file plus per-register rename status, consuming the in-order commit broadcast from the reorder buffer: cdb_tag, cdb_val and cdb_active.
- The decode/issue stage marks destination registers busy with a 4-bit ROB tag.
- The block supplies source operands to the reservation station and load/store buffer, either as a value or as a pending tag.
- Commit writes values back by tag match, with no rd field needed. A branch mispredict clears all pending status.

Parameters:
REG_NUM, 32, number of architectural registers (x0 hardwired zero)
REG_W, 5, register index width
TAG_W, 4, ROB tag width
XLEN, 32, data width

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global ready; low = pause, all state held
issue_valid  input  1  rename destination this cycle
issue_rd  input  REG_W  destination register
issue_tag  input  TAG_W  ROB tag of new producer
commit_valid  input  1  ROB commit, driven by cdb_active
commit_tag  input  TAG_W  committed tag, driven by cdb_tag
commit_val  input  XLEN  committed value, driven by cdb_val
predict_fail  input  1  flush from branch predictor
rs1_idx  input  REG_W  source 1 index
rs2_idx  input  REG_W  source 2 index
rs1_val  output  XLEN  source 1 value (valid when rs1_ready)
rs1_tag  output  TAG_W  source 1 pending tag (valid when !rs1_ready)
rs1_ready  output  1  source 1 value available
rs2_val  output  XLEN  as rs1
rs2_tag  output  TAG_W  as rs1
rs2_ready  output  1  as rs1

Behaviour:
- State per register r: val[r] (XLEN), busy[r] (1), tag[r] (TAG_W).
- Reset, synchronous on rst_in high at posedge, priority over everything:
  - all val = 0, busy = 0, tag = 0.
  - Outputs after reset: ready = 1, val = 0, tag = 0 for any index.
- rdy_in low and not reset: no state change; outputs stay combinational on held state.
- Read ports are combinational and use pre-edge state plus a same-cycle commit bypass:
  - idx == 0: ready = 1, val = 0, tag = 0, always.
  - busy[idx] && commit_valid && commit_tag == tag[idx]: ready = 1, val = commit_val.
  - busy[idx], no match: ready = 0, tag = tag[idx], val = val[idx] (don't-care).
  - otherwise: ready = 1, val = val[idx].
  - A same-cycle issue does NOT affect reads. Sources are read before the destination is renamed, so add x1,x1,x2 sees the old x1 status.
- Commit, at posedge with rdy_in high: for every r != 0 with busy[r] && tag[r] == commit_tag, set val[r] <= commit_val and busy[r] <= 0. This is a CAM match, so at most one register should match; multiple matches are all written.
- Issue, at posedge with rdy_in high and !predict_fail: if issue_rd != 0, set busy[issue_rd] <= 1 and tag[issue_rd] <= issue_tag. issue_rd == 0 is ignored.
- Commit and issue to the same register in the same cycle: val is written, busy stays 1, tag becomes issue_tag. The issue wins over the commit clear.
- predict_fail high with rdy_in high:
  - the commit, if valid, still writes val;
  - all busy are then cleared;
  - issue is ignored.
  - Net result: busy = 0 for all registers.
- x0: val[0], busy[0] and tag[0] remain 0 permanently.
- Tag reuse after wrap-around is safe, because a newer issue overwrites tag[r].

Test Plan:
- Reset, then read rs1_idx = 5 and rs2_idx = 0 -> rs1_ready = 1, rs1_val = 0; rs2_ready = 1, rs2_val = 0.
- Issue rd = 3, tag = 7; next cycle read rs1_idx = 3 -> rs1_ready = 0, rs1_tag = 7. Commit tag 7, val 0xDEADBEEF -> same cycle rs1_ready = 1, rs1_val = 0xDEADBEEF (bypass); next cycle still ready with 0xDEADBEEF.
- Same cycle: commit tag 7 val 0x11 plus issue rd = 3 tag 9, with rs1_idx = 3 -> read that cycle returns ready with 0x11. Next cycle rs1_ready = 0, rs1_tag = 9, and val[3] = 0x11 is retained.
- Issue rd = 4 tag 2 and rd = 6 tag 5 on consecutive cycles, then predict_fail together with an issue of rd = 8 -> next cycle regs 4, 6 and 8 all ready; 4 and 6 return old values.
- Issue rd = 0 tag 1, then commit tag 1 val 0x55 -> x0 reads ready with 0 throughout.
- Issue rd = 2 tag 3, hold rdy_in low, and drive commit tag 3 val 0x99 -> x2 stays not ready. Raise rdy_in and commit again -> val 0x99, ready.
